add_seq: RTL and testbench

- Multi-cycle 32-bit adder: the additive counterpart of the processor's DSP-style subtract path.
- Splits operands into two 16-bit halves, mirroring the DSP top/bottom slice split, and adds low half then high half through one shared 16-bit slice with a registered carry.
- Operands are accepted with a valid/ready handshake; a registered sum and flags are returned with a second valid/ready handshake.
- Sits beside the ALU as a shared arithmetic resource for multi-cycle instructions.

---
 rtl/add_seq_pkg.sv | 28 ++
 rtl/add_seq_slice.sv | 22 ++
 rtl/add_seq.sv | 162 ++++++++++++++++
 tb/tb_add_seq.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_seq_pkg.sv
// add_seq_pkg: shared types and constants for the multi-cycle add_seq adder.
// Holds the FSM state encoding, the default slice width, the operation
// select codes and a small helper for signed-overflow detection.
package add_seq_pkg;

    // Default slice width; the top derives its own HALF from WIDTH.
    localparam int HALF_DEFAULT = 16;

    // Operation select codes (latched with the operands when subtract is built in).
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Sequencer states: accept, low slice, high slice, result handshake.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Two's-complement overflow: both addends share a sign that the sum lacks.
    function automatic logic signed_ovf(input logic a_msb,
                                        input logic b_msb,
                                        input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/add_seq_slice.sv
// add_slice: purely combinational HALF-bit adder slice with carry in/out.
// One instance is time-shared by add_seq for both operand halves.
module add_slice #(
    parameter int HALF = 16
) (
    input  logic [HALF-1:0] a,
    input  logic [HALF-1:0] b,
    input  logic            cin,
    output logic [HALF-1:0] sum,
    output logic            cout
);

    logic [HALF:0] full;

    // Widen by one bit so the carry out falls into the top bit of the result.
    always_comb begin
        full = {1'b0, a} + {1'b0, b} + {{HALF{1'b0}}, cin};
        sum  = full[HALF-1:0];
        cout = full[HALF];
    end

endmodule

// File: rtl/add_seq.sv
// add_seq: multi-cycle WIDTH-bit adder built from one shared HALF-bit slice.
// Operands are accepted on a valid/ready handshake, the low half is added in
// LO, the high half (with the registered mid carry) in HI, and the registered
// sum and flags are offered on a second valid/ready handshake from DONE.
// WIDTH must be even and at least 4.
// Optional feature: define ADD_SEQ_SUB_SEL_EN to add the in_sub port, which
// turns the operation into a-b (b inverted, carry-in of 1, carry = not borrow).
module add_seq
    import add_seq_pkg::*;
#(
    parameter int WIDTH = 2 * HALF_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
`ifdef ADD_SEQ_SUB_SEL_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int HALF = WIDTH / 2;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [HALF-1:0]  low_sum;
    logic             c_mid;

    logic             op_sel;
    logic [WIDTH-1:0] b_eff;
    logic             cin_lo;

    logic [HALF-1:0]  slice_a;
    logic [HALF-1:0]  slice_b;
    logic             slice_cin;
    logic [HALF-1:0]  slice_sum;
    logic             slice_cout;

    logic             accept;

    assign accept = (state == ST_IDLE) && in_valid;

`ifdef ADD_SEQ_SUB_SEL_EN
    logic op_reg;

    // Latch the operation alongside the operands so later in_sub changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg <= OP_ADD;
        end else if (accept) begin
            op_reg <= in_sub;
        end
    end

    assign op_sel = op_reg;
`else
    assign op_sel = OP_ADD;
`endif

    // Subtraction is a + ~b + 1; the +1 enters as the low-slice carry-in.
    always_comb begin
        b_eff  = (op_sel == OP_SUB) ? ~b_reg : b_reg;
        cin_lo = (op_sel == OP_SUB);
    end

    // Steer the low or high operand halves into the shared slice.
    always_comb begin
        slice_a   = a_reg[HALF-1:0];
        slice_b   = b_eff[HALF-1:0];
        slice_cin = cin_lo;
        if (state == ST_HI) begin
            slice_a   = a_reg[WIDTH-1:HALF];
            slice_b   = b_eff[WIDTH-1:HALF];
            slice_cin = c_mid;
        end
    end

    add_slice #(
        .HALF (HALF)
    ) u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (slice_cin),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // State register; reset drops any in-flight operation back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: fixed two-step walk through the slices, then wait for the consumer.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (in_valid)  state_next = ST_LO;
            ST_LO:                  state_next = ST_HI;
            ST_HI:                  state_next = ST_DONE;
            ST_DONE: if (out_ready) state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    // Handshake outputs are pure decodes of the current state.
    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
    end

    // Datapath: capture operands, then the low half, then the full result and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            low_sum   <= '0;
            c_mid     <= 1'b0;
            out_sum   <= '0;
            out_carry <= 1'b0;
            out_ovf   <= 1'b0;
            out_zero  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_reg <= in_a;
                        b_reg <= in_b;
                    end
                end
                ST_LO: begin
                    low_sum <= slice_sum;
                    c_mid   <= slice_cout;
                end
                ST_HI: begin
                    out_sum   <= {slice_sum, low_sum};
                    out_carry <= slice_cout;
                    out_ovf   <= signed_ovf(a_reg[WIDTH-1], b_eff[WIDTH-1],
                                            slice_sum[HALF-1]);
                    out_zero  <= (slice_sum == '0) && (low_sum == '0);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_seq.sv
// tb_add_seq: self-checking bench for add_seq. A transaction-level model
// computes each result with full-width arithmetic and tracks the expected
// handshake timing; a compare process checks every output on every negedge.
// Directed cases pin the model with hand-computed literals, then a long
// randomized run exercises handshakes, edge operands and an async reset.
module tb_add_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
`ifdef ADD_SEQ_SUB_SEL_EN
    logic        in_sub = 1'b0;
`endif
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_sum;
    logic        out_carry;
    logic        out_ovf;
    logic        out_zero;

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    // Reference model state
    logic        m_valid = 1'b0;
    int          m_lat = 0;
    logic [31:0] m_sum = '0;
    logic        m_c = 1'b0, m_o = 1'b0, m_z = 1'b0;
    logic [31:0] p_sum = '0;
    logic        p_c = 1'b0, p_o = 1'b0, p_z = 1'b0;

    always #5 clk = ~clk;

    add_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
`ifdef ADD_SEQ_SUB_SEL_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void ref_result(input logic [31:0] a, input logic [31:0] b,
                                       input logic sub, output logic [31:0] s,
                                       output logic c, output logic o, output logic z);
        logic [31:0] be;
        logic [32:0] full;
        be   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, be} + {32'd0, sub};
        s    = full[31:0];
        c    = full[32];
        o    = (a[31] == be[31]) && (s[31] != a[31]);
        z    = (s == 32'd0);
    endfunction

    function automatic logic cur_sub();
`ifdef ADD_SEQ_SUB_SEL_EN
        return in_sub;
`else
        return 1'b0;
`endif
    endfunction

    // Behavioural model: accept when idle, result appears two edges later, held until taken.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0;
            m_lat   = 0;
            m_sum   = '0;
            m_c     = 1'b0;
            m_o     = 1'b0;
            m_z     = 1'b0;
        end else if (m_valid) begin
            if (out_ready) m_valid = 1'b0;
        end else if (m_lat > 0) begin
            m_lat--;
            if (m_lat == 0) begin
                m_valid = 1'b1;
                m_sum   = p_sum;
                m_c     = p_c;
                m_o     = p_o;
                m_z     = p_z;
            end
        end else if (in_valid) begin
            ref_result(in_a, in_b, cur_sub(), p_sum, p_c, p_o, p_z);
            m_lat = 2;
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("in_ready",  {31'd0, in_ready},  {31'd0, (!m_valid && m_lat == 0)});
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            chk("out_sum",   out_sum, m_sum);
            chk("out_carry", {31'd0, out_carry}, {31'd0, m_c});
            chk("out_ovf",   {31'd0, out_ovf},   {31'd0, m_o});
            chk("out_zero",  {31'd0, out_zero},  {31'd0, m_z});
        end
    end

    // Drive one operation at a negedge and check the two-edge latency.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sub);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
`ifdef ADD_SEQ_SUB_SEL_EN
        in_sub   = sub;
`else
        if (sub) $display("[TB] note: subtract request ignored in add-only build");
`endif
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
`ifdef ADD_SEQ_SUB_SEL_EN
        in_sub   = 1'($urandom_range(0, 1));
`endif
        @(negedge clk);
        chk("lat_lo", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("lat_hi", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("lat_done", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] s,
                               input logic c, input logic o, input logic z);
        chk({name, "_sum"},   out_sum, s);
        chk({name, "_carry"}, {31'd0, out_carry}, {31'd0, c});
        chk({name, "_ovf"},   {31'd0, out_ovf},   {31'd0, o});
        chk({name, "_zero"},  {31'd0, out_zero},  {31'd0, z});
    endtask

    task automatic takeResult();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'h0000_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #500000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        #2;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_sum",   out_sum, 32'd0);
        cmp_en = 1'b1;
        #1 rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(32'h0000_0005, 32'h0000_0003, 1'b0);
        checkOutput("basic", 32'h0000_0008, 1'b0, 1'b0, 1'b0);
        takeResult();

        applyStimulus(32'h0000_FFFF, 32'h0000_0001, 1'b0);
        checkOutput("midcarry", 32'h0001_0000, 1'b0, 1'b0, 1'b0);
        takeResult();

        applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        checkOutput("wrap", 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        takeResult();

        applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        checkOutput("posovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        takeResult();

        applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b0);
        checkOutput("negovf", 32'h0000_0000, 1'b1, 1'b1, 1'b1);
        takeResult();

        // Async reset while a result is waiting in DONE.
        applyStimulus(32'h0000_0005, 32'h0000_0003, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_out_sum",   out_sum, 32'd0);
        chk("midrst_in_ready",  {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // Backpressure: result held while new operands are offered and ignored.
        applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b0);
        checkOutput("bp", 32'h2345_6789, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_a     = 32'h0000_0001;
        in_b     = 32'h0000_0002;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold_sum",   out_sum, 32'h2345_6789);
            chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("bp_idle_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("bp_second_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("bp_second", 32'h0000_0003, 1'b0, 1'b0, 1'b0);
        takeResult();

`ifdef ADD_SEQ_SUB_SEL_EN
        applyStimulus(32'h0000_0003, 32'h0000_0005, 1'b1);
        checkOutput("sub_neg", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        takeResult();
        applyStimulus(32'h0000_0005, 32'h0000_0003, 1'b1);
        checkOutput("sub_pos", 32'h0000_0002, 1'b1, 1'b0, 1'b0);
        takeResult();
        applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b1);
        checkOutput("sub_ovf", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        takeResult();
`endif

        // Randomized traffic with edge-value operands and one mid-run reset.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            in_valid  = 1'($urandom_range(0, 1));
            in_a      = pick();
            in_b      = pick();
`ifdef ADD_SEQ_SUB_SEL_EN
            in_sub    = 1'($urandom_range(0, 1));
`endif
            out_ready = ($urandom_range(0, 3) != 0);
            if (i == 1500) begin
                #2 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (5) @(negedge clk);
        cmp_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
